// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-requester data-memory arbiter with byte-enabled read-modify-write stores
module dm_arbiter #(
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        r0_req,
    input  logic        r0_we,
    input  logic [3:0]  r0_be,
    input  logic [31:0] r0_addr,
    input  logic [31:0] r0_wdata,
    output logic        r0_ack,
    output logic [31:0] r0_rdata,
    input  logic        r1_req,
    input  logic        r1_we,
    input  logic [3:0]  r1_be,
    input  logic [31:0] r1_addr,
    input  logic [31:0] r1_wdata,
    output logic        r1_ack,
    output logic [31:0] r1_rdata,
    output logic        busy,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wd,
    output logic        dm_we,
    input  logic [31:0] dm_rd
);

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, DONE} state_t;

    state_t      state_q;
    logic        win_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [29:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;
    logic        last_grant_q;
    logic        r0_ack_q;
    logic        r1_ack_q;
    logic [31:0] r0_rdata_q;
    logic [31:0] r1_rdata_q;
    logic        dm_we_q;

    logic        grant_d;
    logic        sel_we;
    logic [3:0]  sel_be;
    logic [29:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [31:0] merge_wd;
    logic        unused_addr_lsbs;

    // Byte offset bits never reach DM; the word address is all that is latched.
    assign unused_addr_lsbs = ^{r0_addr[1:0], r1_addr[1:0]};

    // Winner selection: a lone requester wins; ties go to port 0 (fixed) or away from the last grant.
    always_comb begin
        grant_d = 1'b0;
        if (r0_req && r1_req) begin
            grant_d = PRIO_FIXED ? 1'b0 : ~last_grant_q;
        end else begin
            grant_d = r1_req;
        end
    end

    assign sel_we    = grant_d ? r1_we    : r0_we;
    assign sel_be    = grant_d ? r1_be    : r0_be;
    assign sel_addr  = grant_d ? r1_addr[31:2] : r0_addr[31:2];
    assign sel_wdata = grant_d ? r1_wdata : r0_wdata;

    // Merge enabled store bytes over the word read back during ACCESS.
    always_comb begin
        merge_wd = merge_q;
        for (int i = 0; i < 4; i++) begin
            if (be_q[i]) begin
                merge_wd[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end

    // Main sequencer: grant, DM access, optional write-back, one-cycle ack.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            win_q        <= 1'b0;
            we_q         <= 1'b0;
            be_q         <= 4'h0;
            addr_q       <= 30'h0;
            wdata_q      <= 32'h0;
            merge_q      <= 32'h0;
            last_grant_q <= 1'b1;
            r0_ack_q     <= 1'b0;
            r1_ack_q     <= 1'b0;
            r0_rdata_q   <= 32'h0;
            r1_rdata_q   <= 32'h0;
            dm_we_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (r0_req || r1_req) begin
                        win_q        <= grant_d;
                        last_grant_q <= grant_d;
                        we_q         <= sel_we;
                        be_q         <= sel_be;
                        addr_q       <= sel_addr;
                        wdata_q      <= sel_wdata;
                        dm_we_q      <= sel_we && (sel_be == 4'hF);
                        state_q      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (we_q && (be_q != 4'hF) && (be_q != 4'h0)) begin
                        merge_q <= dm_rd;
                        dm_we_q <= 1'b1;
                        state_q <= WRITE;
                    end else begin
                        if (!we_q) begin
                            if (win_q) begin
                                r1_rdata_q <= dm_rd;
                            end else begin
                                r0_rdata_q <= dm_rd;
                            end
                        end
                        dm_we_q  <= 1'b0;
                        r0_ack_q <= ~win_q;
                        r1_ack_q <= win_q;
                        state_q  <= DONE;
                    end
                end
                WRITE: begin
                    dm_we_q  <= 1'b0;
                    r0_ack_q <= ~win_q;
                    r1_ack_q <= win_q;
                    state_q  <= DONE;
                end
                DONE: begin
                    r0_ack_q <= 1'b0;
                    r1_ack_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Write strobe is gated by reset so an aborted access never touches DM.
    assign dm_we    = dm_we_q & reset;
    assign dm_wd    = dm_we ? ((state_q == WRITE) ? merge_wd : wdata_q) : 32'h0;
    assign dm_addr  = {addr_q, 2'b00};
    assign busy     = (state_q != IDLE);
    assign r0_ack   = r0_ack_q;
    assign r1_ack   = r1_ack_q;
    assign r0_rdata = r0_rdata_q;
    assign r1_rdata = r1_rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - self-checking bench for dm_arbiter with a transaction-level reference model
module tb_dm_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        p_req   [2];
    logic        p_we    [2];
    logic [3:0]  p_be    [2];
    logic [31:0] p_addr  [2];
    logic [31:0] p_wdata [2];

    logic        r0_ack, r1_ack, busy, dm_we;
    logic [31:0] r0_rdata, r1_rdata, dm_addr, dm_wd, dm_rd;

    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];

    assign dm_rd = mem[dm_addr[7:2]];

    // DM model: write at the rising edge ending a cycle with dm_we high
    always @(posedge clk) begin
        if (dm_we) mem[dm_addr[7:2]] = dm_wd;
    end

    dm_arbiter #(.PRIO_FIXED(1'b0)) dut (
        .clk(clk), .reset(reset),
        .r0_req(p_req[0]), .r0_we(p_we[0]), .r0_be(p_be[0]), .r0_addr(p_addr[0]), .r0_wdata(p_wdata[0]),
        .r0_ack(r0_ack), .r0_rdata(r0_rdata),
        .r1_req(p_req[1]), .r1_we(p_we[1]), .r1_be(p_be[1]), .r1_addr(p_addr[1]), .r1_wdata(p_wdata[1]),
        .r1_ack(r1_ack), .r1_rdata(r1_rdata),
        .busy(busy), .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_we(dm_we), .dm_rd(dm_rd)
    );

    logic        fx_req0, fx_req1, fx_ack0, fx_ack1, fx_busy, fx_we;
    logic [31:0] fx_rdata0, fx_rdata1, fx_addr, fx_wd, fx_rd;
    assign fx_rd = {16'hA5A5, fx_addr[15:0]};

    dm_arbiter #(.PRIO_FIXED(1'b1)) dut_fx (
        .clk(clk), .reset(reset),
        .r0_req(fx_req0), .r0_we(1'b0), .r0_be(4'h0), .r0_addr(32'h40), .r0_wdata(32'h0),
        .r0_ack(fx_ack0), .r0_rdata(fx_rdata0),
        .r1_req(fx_req1), .r1_we(1'b0), .r1_be(4'h0), .r1_addr(32'h80), .r1_wdata(32'h0),
        .r1_ack(fx_ack1), .r1_rdata(fx_rdata1),
        .busy(fx_busy), .dm_addr(fx_addr), .dm_wd(fx_wd), .dm_we(fx_we), .dm_rd(fx_rd)
    );

    int          checks = 0;
    int          errors = 0;
    bit          chk_en = 1'b0;
    bit          exp_busy, exp_we, addr_chk;
    bit          exp_ack   [2];
    logic [31:0] exp_rdata [2];
    logic [31:0] exp_wd, exp_addr, acc_addr;
    int          last = 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Per-cycle comparison against the model's expectations
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, exp_busy);
            chk("r0_ack", r0_ack, exp_ack[0]);
            chk("r1_ack", r1_ack, exp_ack[1]);
            chk("r0_rdata", r0_rdata, exp_rdata[0]);
            chk("r1_rdata", r1_rdata, exp_rdata[1]);
            chk("dm_we", dm_we, exp_we);
            chk("dm_wd", dm_wd, exp_wd);
            if (addr_chk) chk("dm_addr", dm_addr, exp_addr);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] merge_fn(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (nw & mask) | (old & ~mask);
    endfunction

    task automatic new_req(input int p);
        if (!p_req[p] && $urandom_range(0, 3) != 0) begin
            p_req[p] = 1'b1;
            p_we[p]  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       p_be[p] = 4'hF;
                1:       p_be[p] = 4'h0;
                default: p_be[p] = 4'($urandom_range(1, 14));
            endcase
            if ($urandom_range(0, 9) == 0)
                p_addr[p] = {30'h3FFF_FFFF, 2'($urandom_range(0, 3))};
            else
                p_addr[p] = {27'h0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            p_wdata[p] = $urandom();
        end
    endtask

    // One arbitration round starting at an IDLE cycle; ends at the start of the next IDLE cycle
    task automatic round(input bit gen);
        int          w;
        logic [31:0] a;
        logic [5:0]  idx;
        bit          partial;
        if (gen) begin
            new_req(0);
            new_req(1);
        end
        exp_busy = 1'b0; exp_ack[0] = 1'b0; exp_ack[1] = 1'b0;
        exp_we = 1'b0; exp_wd = 32'h0; addr_chk = 1'b0;
        if (!p_req[0] && !p_req[1]) begin
            step();
            return;
        end
        if (p_req[0] && p_req[1]) w = (last == 0) ? 1 : 0;
        else                      w = p_req[1] ? 1 : 0;
        last    = w;
        a       = {p_addr[w][31:2], 2'b00};
        idx     = a[7:2];
        partial = p_we[w] && (p_be[w] != 4'hF) && (p_be[w] != 4'h0);
        step();
        acc_addr = dm_addr;
        exp_busy = 1'b1; addr_chk = 1'b1; exp_addr = a;
        if (p_we[w] && p_be[w] == 4'hF) begin
            exp_we = 1'b1;
            exp_wd = p_wdata[w];
            ref_mem[idx] = p_wdata[w];
        end
        if (partial) begin
            step();
            exp_we = 1'b1;
            exp_wd = merge_fn(ref_mem[idx], p_wdata[w], p_be[w]);
            ref_mem[idx] = exp_wd;
        end
        step();
        exp_we = 1'b0; exp_wd = 32'h0; addr_chk = 1'b0; exp_ack[w] = 1'b1;
        if (!p_we[w]) exp_rdata[w] = ref_mem[idx];
        step();
        exp_ack[w] = 1'b0; exp_busy = 1'b0;
        p_req[w] = 1'b0;
    endtask

    task automatic set_req(input int p, input logic we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata);
        p_req[p] = 1'b1; p_we[p] = we; p_be[p] = be; p_addr[p] = addr; p_wdata[p] = wdata;
    endtask

    initial begin
        int a0, a1, a1cyc;
        for (int i = 0; i < 64; i++) begin
            mem[i]     = $urandom();
            ref_mem[i] = mem[i];
        end
        reset = 1'b0;
        fx_req0 = 1'b0; fx_req1 = 1'b0;
        for (int p = 0; p < 2; p++) begin
            p_req[p] = 1'b0; p_we[p] = 1'b0; p_be[p] = 4'h0; p_addr[p] = 32'h0; p_wdata[p] = 32'h0;
            exp_ack[p] = 1'b0; exp_rdata[p] = 32'h0;
        end
        exp_busy = 1'b0; exp_we = 1'b0; exp_wd = 32'h0; addr_chk = 1'b0; exp_addr = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        chk("reset_dm_addr", dm_addr, 32'h0);
        chk("reset_fx_busy", fx_busy, 32'h0);
        chk_en = 1'b1;

        // Fixed priority: r0 re-requesting continuously starves r1 until it drops
        fx_req0 = 1'b1; fx_req1 = 1'b1;
        a0 = 0; a1 = 0; a1cyc = -1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (fx_ack0) a0++;
            if (fx_ack1) begin a1++; a1cyc = c; end
            step();
            if (c == 11) fx_req0 = 1'b0;
        end
        fx_req1 = 1'b0;
        chk("fx_r0_acks", 32'(a0), 32'd4);
        chk("fx_r1_acks", 32'(a1), 32'd1);
        chk("fx_r1_ack_cycle", 32'(a1cyc), 32'd14);
        chk("fx_r0_rdata", fx_rdata0, 32'hA5A5_0040);
        chk("fx_r1_rdata", fx_rdata1, 32'hA5A5_0080);

        // First tie after reset goes to r0, then r1
        mem[4] = 32'h1234_5678; ref_mem[4] = 32'h1234_5678;
        mem[8] = 32'hCAFE_F00D; ref_mem[8] = 32'hCAFE_F00D;
        set_req(0, 1'b0, 4'hF, 32'h13, 32'h0);
        set_req(1, 1'b0, 4'h0, 32'h20, 32'h0);
        round(0);
        chk("tie_r0_first", r0_rdata, 32'h1234_5678);
        chk("tie_r1_waits", r1_rdata, 32'h0);
        round(0);
        chk("tie_r1_second", r1_rdata, 32'hCAFE_F00D);

        set_req(1, 1'b1, 4'hF, 32'h20, 32'hDEAD_BEEF);
        round(0);
        set_req(1, 1'b0, 4'h0, 32'h20, 32'h0);
        round(0);
        chk("full_store_readback", r1_rdata, 32'hDEAD_BEEF);

        set_req(0, 1'b1, 4'b0010, 32'h20, 32'h0000_AA00);
        round(0);
        chk("rmw_mem", mem[8], 32'hDEAD_AAEF);

        set_req(1, 1'b1, 4'h0, 32'h22, 32'hFFFF_FFFF);
        round(0);
        chk("empty_store_mem", mem[8], 32'hDEAD_AAEF);

        set_req(0, 1'b0, 4'h0, 32'hFFFF_FFFE, 32'h0);
        round(0);
        chk("top_addr", acc_addr, 32'hFFFF_FFFC);

        // Reset asserted during ACCESS of a full store
        mem[12] = 32'h0BAD_F00D; ref_mem[12] = 32'h0BAD_F00D;
        set_req(0, 1'b1, 4'hF, 32'h30, 32'h1111_1111);
        step();
        chk_en = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_dm_we", dm_we, 32'h0);
        chk("rst_mid_dm_wd", dm_wd, 32'h0);
        step();
        p_req[0] = 1'b0;
        reset = 1'b1;
        chk("rst_mid_mem", mem[12], 32'h0BAD_F00D);
        chk("rst_mid_busy", busy, 32'h0);
        chk("rst_mid_dm_addr", dm_addr, 32'h0);
        chk("rst_mid_r0_rdata", r0_rdata, 32'h0);
        chk("rst_mid_r1_rdata", r1_rdata, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_mid_no_ack0", r0_ack, 32'h0);
            chk("rst_mid_no_ack1", r1_ack, 32'h0);
        end
        step();
        last = 1;
        exp_rdata[0] = 32'h0; exp_rdata[1] = 32'h0;
        exp_ack[0] = 1'b0; exp_ack[1] = 1'b0;
        exp_busy = 1'b0; exp_we = 1'b0; exp_wd = 32'h0; addr_chk = 1'b0;
        chk_en = 1'b1;

        repeat (400) round(1);

        chk_en = 1'b0;
        for (int i = 0; i < 64; i++) chk("mem_final", mem[i], ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
